// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared constants and types for the two-port mem_bus arbiter.
//                Arbiter state encodings, requester IDs, and the request
//                record latched on grant.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter state encodings
    localparam logic [1:0] c_ARB_IDLE    = 2'd0;
    localparam logic [1:0] c_ARB_GRANT   = 2'd1;
    localparam logic [1:0] c_ARB_RELEASE = 2'd2;

    // Requester IDs
    localparam logic c_REQ_IFETCH = 1'b0;
    localparam logic c_REQ_LSU    = 1'b1;

    // Storage width of the address field; the arbiter narrows it to
    // ADDRESS_SIZE when driving the bus, so ADDRESS_SIZE must not exceed this.
    localparam int c_REQ_ADDR_W = 32;

    // Snapshot of a requester's fields, captured at grant time
    typedef struct packed {
        logic [c_REQ_ADDR_W-1:0] addr;
        logic [2:0]              num_bytes;
        logic                    is_write;
        logic [31:0]             wdata;
    } mem_req_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin arbiter sharing one mem_bus request port between
//                instruction fetch (port 0) and load/store (port 1). Latches
//                the winner's request, drives the start/done handshake, and
//                aborts a transfer whose peripheral never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_SIZE   = 18,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    r0_req,
    input  logic [ADDRESS_SIZE-1:0] r0_addr,
    input  logic [2:0]              r0_num_bytes,
    input  logic                    r0_is_write,
    input  logic [31:0]             r0_wdata,
    output logic                    r0_done,
    output logic                    r0_err,
    input  logic                    r1_req,
    input  logic [ADDRESS_SIZE-1:0] r1_addr,
    input  logic [2:0]              r1_num_bytes,
    input  logic                    r1_is_write,
    input  logic [31:0]             r1_wdata,
    output logic                    r1_done,
    output logic                    r1_err,
    output logic [31:0]             rdata,
    output logic                    busy,
    output logic                    owner,
    output logic [ADDRESS_SIZE-1:0] bus_target_address,
    output logic [2:0]              bus_num_bytes,
    output logic                    bus_is_write,
    output logic [31:0]             bus_write_value,
    output logic                    bus_start_request,
    input  logic [31:0]             bus_fetched_value,
    input  logic                    bus_request_done
);

    // A zero TIMEOUT_CYCLES disables the watchdog; keep a 1-bit timer then
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_TMR_W-1:0] c_TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? c_TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = '1;

    logic [1:0]         r_state;
    mem_req_t           r_req;
    logic               r_owner;
    logic               r_last_grant;
    logic               r_start;
    logic [c_TMR_W-1:0] r_timer;
    logic [31:0]        r_rdata;
    logic [1:0]         r_done;
    logic [1:0]         r_err;

    logic               w_pick_valid;
    logic               w_pick_id;
    mem_req_t           w_pick_req;
    logic               w_timeout;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last
    always_comb begin
        w_pick_valid = r0_req | r1_req;
        if (r0_req && r1_req) begin
            w_pick_id = ~r_last_grant;
        end else begin
            w_pick_id = r1_req ? c_REQ_LSU : c_REQ_IFETCH;
        end
        if (w_pick_id == c_REQ_LSU) begin
            w_pick_req = '{addr: c_REQ_ADDR_W'(r1_addr), num_bytes: r1_num_bytes,
                           is_write: r1_is_write, wdata: r1_wdata};
        end else begin
            w_pick_req = '{addr: c_REQ_ADDR_W'(r0_addr), num_bytes: r0_num_bytes,
                           is_write: r0_is_write, wdata: r0_wdata};
        end
        w_timeout = (TIMEOUT_CYCLES != 0) && (r_timer == c_TMO_LAST);
    end

    // Arbitration FSM: IDLE -> GRANT -> RELEASE -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ARB_IDLE;
            r_req        <= '0;
            r_owner      <= c_REQ_IFETCH;
            r_last_grant <= c_REQ_LSU;
            r_start      <= 1'b0;
            r_timer      <= '0;
            r_rdata      <= '0;
            r_done       <= 2'b00;
            r_err        <= 2'b00;
        end else begin
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_req        <= w_pick_req;
                        r_owner      <= w_pick_id;
                        r_last_grant <= w_pick_id;
                        r_start      <= 1'b1;
                        r_timer      <= '0;
                        r_state      <= c_ARB_GRANT;
                    end
                end
                c_ARB_GRANT: begin
                    // A completion arriving on the timeout cycle still counts as success
                    if (bus_request_done) begin
                        r_rdata          <= bus_fetched_value;
                        r_done[r_owner]  <= 1'b1;
                        r_err[r_owner]   <= 1'b0;
                        r_start          <= 1'b0;
                        r_state          <= c_ARB_RELEASE;
                    end else if (w_timeout) begin
                        r_rdata          <= '0;
                        r_done[r_owner]  <= 1'b1;
                        r_err[r_owner]   <= 1'b1;
                        r_start          <= 1'b0;
                        r_state          <= c_ARB_RELEASE;
                    end else if (r_timer != c_TMR_MAX) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_ARB_RELEASE: begin
                    // One start-low cycle lets mem_bus re-arm before the next grant
                    r_done  <= 2'b00;
                    r_err   <= 2'b00;
                    r_state <= c_ARB_IDLE;
                end
                default: begin
                    r_state <= c_ARB_IDLE;
                end
            endcase
        end
    end

    assign r0_done            = r_done[0];
    assign r1_done            = r_done[1];
    assign r0_err             = r_err[0];
    assign r1_err             = r_err[1];
    assign rdata              = r_rdata;
    assign busy               = (r_state != c_ARB_IDLE);
    assign owner              = r_owner;
    assign bus_target_address = r_req.addr[ADDRESS_SIZE-1:0];
    assign bus_num_bytes      = r_req.num_bytes;
    assign bus_is_write       = r_req.is_write;
    assign bus_write_value    = r_req.wdata;
    assign bus_start_request  = r_start;

endmodule : mem_bus_arbiter
`default_nettype wire
